// File: rtl/lstm_cell_bp.sv
// LSTM cell backward pass: cell-state gradient and the four gate pre-activation
// deltas, computed on one shared saturating Q-format multiplier over 16 steps.
module lstm_cell_bp #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dh,
    input  logic [WIDTH-1:0] i_dc_next,
    input  logic [WIDTH-1:0] i_f_next,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_i,
    input  logic [WIDTH-1:0] i_f,
    input  logic [WIDTH-1:0] i_o,
    input  logic [WIDTH-1:0] i_tanh_c,
    input  logic [WIDTH-1:0] i_c_prev,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_dc,
    output logic [WIDTH-1:0] o_da,
    output logic [WIDTH-1:0] o_di,
    output logic [WIDTH-1:0] o_df,
    output logic [WIDTH-1:0] o_do
);

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t     state_reg, state_next;
    logic [3:0] step_reg;

    logic [WIDTH-1:0] dh_reg, dcn_reg, fn_reg, a_reg, i_reg, f_reg, o_reg, tc_reg, cp_reg;
    logic [WIDTH-1:0] t1_reg, t2_reg, t3_reg, dc_reg, da_reg, di_reg, df_reg;

    logic signed [WIDTH-1:0]   mul_a, mul_b;
    logic signed [2*WIDTH-1:0] prod, prod_shift;
    logic [WIDTH-1:0]          mul_q;

    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH:0] s;
        s = {x[WIDTH-1], x} + {y[WIDTH-1], y};
        if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? SAT_MIN : SAT_MAX;
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH:0] s;
        s = {x[WIDTH-1], x} - {y[WIDTH-1], y};
        if (s[WIDTH] != s[WIDTH-1]) return s[WIDTH] ? SAT_MIN : SAT_MAX;
        return s[WIDTH-1:0];
    endfunction

    // Operand routing for the shared multiplier, one product per step.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (step_reg)
            4'd0:  begin mul_a = tc_reg;  mul_b = tc_reg;                end
            4'd1:  begin mul_a = dh_reg;  mul_b = o_reg;                 end
            4'd2:  begin mul_a = t2_reg;  mul_b = sat_sub(ONE, t1_reg);  end
            4'd3:  begin mul_a = dcn_reg; mul_b = fn_reg;                end
            4'd4:  begin mul_a = dc_reg;  mul_b = i_reg;                 end
            4'd5:  begin mul_a = a_reg;   mul_b = a_reg;                 end
            4'd6:  begin mul_a = t1_reg;  mul_b = sat_sub(ONE, t2_reg);  end
            4'd7:  begin mul_a = dc_reg;  mul_b = a_reg;                 end
            4'd8:  begin mul_a = i_reg;   mul_b = sat_sub(ONE, i_reg);   end
            4'd9:  begin mul_a = t1_reg;  mul_b = t2_reg;                end
            4'd10: begin mul_a = dc_reg;  mul_b = cp_reg;                end
            4'd11: begin mul_a = f_reg;   mul_b = sat_sub(ONE, f_reg);   end
            4'd12: begin mul_a = t1_reg;  mul_b = t2_reg;                end
            4'd13: begin mul_a = dh_reg;  mul_b = tc_reg;                end
            4'd14: begin mul_a = o_reg;   mul_b = sat_sub(ONE, o_reg);   end
            default: begin mul_a = t1_reg; mul_b = t2_reg;               end
        endcase
    end

    always_comb begin
        prod       = mul_a * mul_b;
        prod_shift = prod >>> FRAC;
        // Fits only when the top WIDTH+1 bits are all sign copies.
        if (!prod_shift[2*WIDTH-1] && (|prod_shift[2*WIDTH-2:WIDTH-1]))
            mul_q = SAT_MAX;
        else if (prod_shift[2*WIDTH-1] && !(&prod_shift[2*WIDTH-2:WIDTH-1]))
            mul_q = SAT_MIN;
        else
            mul_q = prod_shift[WIDTH-1:0];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (i_start) state_next = S_CALC;
            S_CALC:  if (step_reg == 4'd15) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            step_reg  <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state_reg <= state_next;
            step_reg  <= (state_reg == S_CALC) ? step_reg + 4'd1 : 4'd0;
            o_busy    <= (state_next != S_IDLE);
            o_done    <= (state_next == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dh_reg <= '0; dcn_reg <= '0; fn_reg <= '0; a_reg <= '0; i_reg <= '0;
            f_reg  <= '0; o_reg   <= '0; tc_reg <= '0; cp_reg <= '0;
            t1_reg <= '0; t2_reg  <= '0; t3_reg <= '0; dc_reg <= '0;
            da_reg <= '0; di_reg  <= '0; df_reg <= '0;
            o_dc <= '0; o_da <= '0; o_di <= '0; o_df <= '0; o_do <= '0;
        end else if (state_reg == S_IDLE) begin
            if (i_start) begin
                dh_reg <= i_dh;  dcn_reg <= i_dc_next; fn_reg <= i_f_next;
                a_reg  <= i_a;   i_reg   <= i_i;       f_reg  <= i_f;
                o_reg  <= i_o;   tc_reg  <= i_tanh_c;  cp_reg <= i_c_prev;
            end
        end else if (state_reg == S_CALC) begin
            case (step_reg)
                4'd0, 4'd4, 4'd7, 4'd10, 4'd13: t1_reg <= mul_q;
                4'd1, 4'd5, 4'd8, 4'd11, 4'd14: t2_reg <= mul_q;
                4'd2:  t3_reg <= mul_q;
                4'd3:  dc_reg <= sat_add(t3_reg, mul_q);
                4'd6:  da_reg <= mul_q;
                4'd9:  di_reg <= mul_q;
                4'd12: df_reg <= mul_q;
                default: begin
                    // Last product goes straight out with the stored results.
                    o_dc <= dc_reg;
                    o_da <= da_reg;
                    o_di <= di_reg;
                    o_df <= df_reg;
                    o_do <= mul_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_cell_bp.sv
// Bench for lstm_cell_bp: directed and random ops compared against a
// fixed-point reference of the backward-pass equations.
module tb_lstm_cell_bp;

    localparam logic [31:0] ONE = 32'h01000000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_dh, i_dc_next, i_f_next, i_a, i_i, i_f, i_o, i_tanh_c, i_c_prev;
    logic        o_busy, o_done;
    logic [31:0] o_dc, o_da, o_di, o_df, o_do;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] dh, dcn, fn, a, i, f, o, tc, cp;
    } op_t;
    typedef struct {
        logic [31:0] dc, da, di, df, dov;
    } res_t;

    res_t last;

    lstm_cell_bp #(.WIDTH(32), .FRAC(24)) dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .i_dh(i_dh), .i_dc_next(i_dc_next), .i_f_next(i_f_next),
        .i_a(i_a), .i_i(i_i), .i_f(i_f), .i_o(i_o),
        .i_tanh_c(i_tanh_c), .i_c_prev(i_c_prev),
        .o_busy(o_busy), .o_done(o_done),
        .o_dc(o_dc), .o_da(o_da), .o_di(o_di), .o_df(o_df), .o_do(o_do)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat(input longint v);
        if (v > 64'sd2147483647) return 32'h7FFFFFFF;
        if (v < -64'sd2147483648) return 32'h80000000;
        return v[31:0];
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return sat(p >>> 24);
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        return sat(longint'($signed(x)) + longint'($signed(y)));
    endfunction

    function automatic logic [31:0] fsub(input logic [31:0] x, input logic [31:0] y);
        return sat(longint'($signed(x)) - longint'($signed(y)));
    endfunction

    // dc = dh*o*(1-tanh^2) + dc_next*f_next, then the sigmoid/tanh derivative gates.
    function automatic res_t model(input op_t x);
        res_t r;
        r.dc  = fadd(fmul(fmul(x.dh, x.o), fsub(ONE, fmul(x.tc, x.tc))), fmul(x.dcn, x.fn));
        r.da  = fmul(fmul(r.dc, x.i), fsub(ONE, fmul(x.a, x.a)));
        r.di  = fmul(fmul(r.dc, x.a), fmul(x.i, fsub(ONE, x.i)));
        r.df  = fmul(fmul(r.dc, x.cp), fmul(x.f, fsub(ONE, x.f)));
        r.dov = fmul(fmul(x.dh, x.tc), fmul(x.o, fsub(ONE, x.o)));
        return r;
    endfunction

    function automatic logic [31:0] rnd(input bit big);
        if (big) return $urandom;
        return 32'($urandom_range(0, 32'h03FFFFFF)) - 32'h02000000;
    endfunction

    function automatic op_t rand_op(input bit big);
        op_t x;
        x.dh = rnd(big); x.dcn = rnd(big); x.fn = rnd(big); x.a = rnd(big);
        x.i  = rnd(big); x.f   = rnd(big); x.o  = rnd(big); x.tc = rnd(big);
        x.cp = rnd(big);
        return x;
    endfunction

    function automatic op_t mk(input logic [31:0] dh, dcn, fn, a, i, f, o, tc, cp);
        op_t x;
        x.dh = dh; x.dcn = dcn; x.fn = fn; x.a = a; x.i = i;
        x.f = f; x.o = o; x.tc = tc; x.cp = cp;
        return x;
    endfunction

    task automatic drive(input op_t x);
        i_dh = x.dh; i_dc_next = x.dcn; i_f_next = x.fn; i_a = x.a; i_i = x.i;
        i_f = x.f; i_o = x.o; i_tanh_c = x.tc; i_c_prev = x.cp;
    endtask

    task automatic check_res(input string tag, input res_t e);
        check({tag, "_dc"}, o_dc, e.dc);
        check({tag, "_da"}, o_da, e.da);
        check({tag, "_di"}, o_di, e.di);
        check({tag, "_df"}, o_df, e.df);
        check({tag, "_do"}, o_do, e.dov);
    endtask

    // Waits from just after the accepting edge until o_done; checks latency,
    // output hold mid-op, results, and the one-cycle pulse.
    task automatic finish_op(input string tag, input res_t e, input bit poke);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); n++; #1;
            if (poke && n == 4) begin i_start = 1'b1; drive(rand_op(1'b1)); end
            if (poke && n == 5) i_start = 1'b0;
            if (n == 8) check_res({tag, "_hold"}, last);
            if (o_done) seen = 1'b1;
        end
        check({tag, "_latency"}, 32'(n), 32'd16);
        check_res(tag, e);
        last = e;
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {31'd0, o_done}, 32'd0);
        check({tag, "_busy_end"}, {31'd0, o_busy}, 32'd0);
    endtask

    task automatic run_op(input string tag, input op_t x, input bit poke);
        res_t e;
        e = model(x);
        @(negedge clk); drive(x); i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        check({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
        drive(rand_op(1'b1));
        finish_op(tag, e, poke);
        $display("op %s dc=%h da=%h di=%h df=%h do=%h", tag, o_dc, o_da, o_di, o_df, o_do);
    endtask

    op_t mixed;

    initial begin
        int   dones;
        op_t  xs[3];
        mixed = mk(ONE, 32'h00800000, 32'h00800000, 32'h00800000, 32'h00800000,
                   32'h00800000, 32'h00800000, 32'h00800000, ONE);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        last = '{default: 32'h0};
        #12;
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check_res("rst", last);
        @(negedge clk); rst = 1'b1;

        run_op("trivial", mk(ONE, 0, 0, 0, ONE, 0, ONE, 0, 0), 1'b0);
        check("trivial_const_dc", o_dc, 32'h01000000);
        check("trivial_const_da", o_da, 32'h01000000);
        run_op("mixed", mixed, 1'b0);
        check("mixed_const_dc", o_dc, 32'h00A00000);
        check("mixed_const_da", o_da, 32'h003C0000);
        check("mixed_const_di", o_di, 32'h00140000);
        check("mixed_const_df", o_df, 32'h00280000);
        check("mixed_const_do", o_do, 32'h00200000);
        run_op("neg", mk(32'hFF000000, 0, 0, 0, ONE, 0, ONE, 0, 0), 1'b0);
        check("neg_const_dc", o_dc, 32'hFF000000);
        check("neg_const_da", o_da, 32'hFF000000);
        run_op("sat", mk(32'h64000000, 32'h64000000, ONE, 0, ONE, 0, 32'h64000000, 0, 0), 1'b0);
        check("sat_const_dc", o_dc, 32'h7FFFFFFF);
        check("sat_const_da", o_da, 32'h7FFFFFFF);

        // Start pulse mid-op must be ignored; count dones over a window after.
        run_op("poke", mixed, 1'b1);
        dones = 0;
        repeat (20) begin @(posedge clk); #1; if (o_done) dones++; end
        check("poke_extra_done", 32'(dones), 32'd0);

        // Asynchronous reset mid-op.
        @(negedge clk); drive(rand_op(1'b0)); i_start = 1'b1;
        @(posedge clk); #1; i_start = 1'b0;
        repeat (8) @(posedge clk);
        #2; rst = 1'b0; #1;
        check("midrst_busy", {31'd0, o_busy}, 32'd0);
        check("midrst_done", {31'd0, o_done}, 32'd0);
        last = '{default: 32'h0};
        check_res("midrst", last);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        dones = 0;
        repeat (20) begin @(posedge clk); #1; if (o_done) dones++; end
        check("midrst_no_done", 32'(dones), 32'd0);
        run_op("mixed_after_rst", mixed, 1'b0);

        // i_start held high across three back-to-back ops.
        for (int k = 0; k < 3; k++) xs[k] = rand_op(k == 1);
        @(negedge clk); drive(xs[0]); i_start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("cont%0d_accept", k), {31'd0, o_busy}, 32'd1);
            if (k < 2) drive(xs[k+1]);
            else i_start = 1'b0;
            finish_op($sformatf("cont%0d", k), model(xs[k]), 1'b0);
            $display("op cont%0d dc=%h da=%h di=%h df=%h do=%h", k, o_dc, o_da, o_di, o_df, o_do);
        end

        for (int k = 0; k < 8; k++) run_op($sformatf("rand%0d", k), rand_op(k[0]), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
